// File: rtl/jk_bank_driver_pkg.sv
// rtl/jk_bank_driver_pkg.sv - shared encodings and helpers for the JK bank driver
// Purpose: request mode encodings, driver FSM state type, error counter width
//          and a saturating increment used by the error counter.
package jk_bank_driver_pkg;

    localparam logic [1:0] MODE_LOAD   = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_CLEAR  = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    localparam int ERR_COUNT_W = 8;
    localparam logic [ERR_COUNT_W-1:0] ERR_COUNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    function automatic logic [ERR_COUNT_W-1:0] sat_inc(input logic [ERR_COUNT_W-1:0] v);
        return (v == ERR_COUNT_MAX) ? v : v + {{(ERR_COUNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/jk_bank_driver_excite.sv
// rtl/jk_bank_driver_excite.sv - per-bit JK excitation cell
// Purpose: combinational J/K drive that moves one JK flip-flop from q to t.
// Ports:
//   q    current flip-flop output
//   t    target value
//   hold force J=K=0 regardless of q/t
//   j, k excitation outputs
// DC_POLICY is the value used for the don't-care half of each entry:
// 0 yields hold/set/reset encodings, 1 yields toggle encodings.
module jk_excite #(
    parameter bit DC_POLICY = 1'b0
) (
    input  logic q,
    input  logic t,
    input  logic hold,
    output logic j,
    output logic k
);

    always_comb begin
        j = 1'b0;
        k = 1'b0;
        if (!hold) begin
            if (!q) begin
                j = t;
                k = DC_POLICY;
            end else begin
                j = DC_POLICY;
                k = ~t;
            end
        end
    end

endmodule

// File: rtl/jk_bank_driver.sv
// rtl/jk_bank_driver.sv - JK flip-flop bank driver with post-drive verification
// Purpose: accepts target requests, drives J/K for one cycle, then compares
//          the bank output with the target and records mismatches.
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   IN_VALID/IN_READY     request handshake; IN_MODE selects LOAD/TOGGLE/CLEAR/HOLD
//   IN_DATA               LOAD target or TOGGLE mask
//   Q_FB                  Q outputs of the driven bank
//   J, K                  registered excitation to the bank
//   BUSY, DONE            operation in progress, one-cycle completion pulse
//   ERR, ERR_MASK         sticky mismatch flag, mismatch bits of the latest check
//   ERR_COUNT, ERR_CLR    saturating failed-check count, synchronous clear
module jk_bank_driver
    import jk_bank_driver_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit DC_POLICY = 1'b0
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [1:0]             IN_MODE,
    input  logic [WIDTH-1:0]       IN_DATA,
    input  logic [WIDTH-1:0]       Q_FB,
    output logic [WIDTH-1:0]       J,
    output logic [WIDTH-1:0]       K,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   ERR,
    output logic [WIDTH-1:0]       ERR_MASK,
    output logic [ERR_COUNT_W-1:0] ERR_COUNT,
    input  logic                   ERR_CLR
);

    state_t                   state_q, state_d;
    logic [WIDTH-1:0]         target_q, target_d;
    logic [WIDTH-1:0]         j_d, k_d;
    logic [WIDTH-1:0]         mismatch;
    logic [ERR_COUNT_W-1:0]   cnt_base;
    logic                     accept;
    logic                     hold;

    // Ready is gated by RST so nothing can be accepted while reset is held.
    assign IN_READY = (state_q == ST_IDLE) && !RST;
    assign accept   = IN_VALID && IN_READY;
    assign BUSY     = (state_q != ST_IDLE);
    assign hold     = (IN_MODE == MODE_HOLD);
    assign mismatch = Q_FB ^ target_q;
    // ERR_CLR coincident with a failing check clears first, then records.
    assign cnt_base = ERR_CLR ? '0 : ERR_COUNT;

    always_comb begin
        target_d = Q_FB;
        case (IN_MODE)
            MODE_LOAD:   target_d = IN_DATA;
            MODE_TOGGLE: target_d = Q_FB ^ IN_DATA;
            MODE_CLEAR:  target_d = '0;
            default:     target_d = Q_FB;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_excite
        jk_excite #(.DC_POLICY(DC_POLICY)) u_excite (
            .q    (Q_FB[i]),
            .t    (target_d[i]),
            .hold (hold),
            .j    (j_d[i]),
            .k    (k_d[i])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_DRIVE;
            ST_DRIVE: state_d = ST_CHECK;
            ST_CHECK: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            J         <= '0;
            K         <= '0;
            target_q  <= '0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            ERR_MASK  <= '0;
            ERR_COUNT <= '0;
        end else begin
            // J/K default to zero so the drive lasts exactly the DRIVE cycle.
            J    <= '0;
            K    <= '0;
            DONE <= 1'b0;
            if (accept) begin
                target_q <= target_d;
                J        <= j_d;
                K        <= k_d;
            end
            if (ERR_CLR) begin
                ERR       <= 1'b0;
                ERR_MASK  <= '0;
                ERR_COUNT <= '0;
            end
            if (state_q == ST_CHECK) begin
                DONE     <= 1'b1;
                ERR_MASK <= mismatch;
                if (|mismatch) begin
                    ERR       <= 1'b1;
                    ERR_COUNT <= sat_inc(cnt_base);
                end
            end
        end
    end

endmodule

// File: tb/tb_jk_bank_driver.sv
// tb/tb_jk_bank_driver.sv - self-checking bench for jk_bank_driver
module tb_jk_bank_driver;
    import jk_bank_driver_pkg::*;

    localparam int W = 8;

    logic CLK = 1'b0;
    logic RST;
    logic rst_n;
    always #5 CLK = ~CLK;
    assign rst_n = ~RST;

    logic         in_valid;
    logic [1:0]   in_mode;
    logic [W-1:0] in_data;
    logic         err_clr;
    logic [W-1:0] stuck;

    logic         in_ready  [2];
    logic [W-1:0] j_o       [2];
    logic [W-1:0] k_o       [2];
    logic         busy      [2];
    logic         done      [2];
    logic         err       [2];
    logic [W-1:0] err_mask  [2];
    logic [7:0]   err_count [2];
    logic [W-1:0] q_reg     [2];
    logic [W-1:0] q_fb      [2];

    logic         m_err  [2];
    logic [7:0]   m_cnt  [2];
    logic [W-1:0] m_mask [2];

    int checks   = 0;
    int failures = 0;

    jk_bank_driver #(.WIDTH(W), .DC_POLICY(1'b0)) dut0 (
        .CLK(CLK), .RST(RST), .IN_VALID(in_valid), .IN_READY(in_ready[0]),
        .IN_MODE(in_mode), .IN_DATA(in_data), .Q_FB(q_fb[0]), .J(j_o[0]), .K(k_o[0]),
        .BUSY(busy[0]), .DONE(done[0]), .ERR(err[0]), .ERR_MASK(err_mask[0]),
        .ERR_COUNT(err_count[0]), .ERR_CLR(err_clr)
    );

    jk_bank_driver #(.WIDTH(W), .DC_POLICY(1'b1)) dut1 (
        .CLK(CLK), .RST(RST), .IN_VALID(in_valid), .IN_READY(in_ready[1]),
        .IN_MODE(in_mode), .IN_DATA(in_data), .Q_FB(q_fb[1]), .J(j_o[1]), .K(k_o[1]),
        .BUSY(busy[1]), .DONE(done[1]), .ERR(err[1]), .ERR_MASK(err_mask[1]),
        .ERR_COUNT(err_count[1]), .ERR_CLR(err_clr)
    );

    // JK bank: hold / reset / set / toggle; stuck bits read as 0.
    assign q_fb[0] = q_reg[0] & ~stuck;
    assign q_fb[1] = q_reg[1] & ~stuck;

    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            q_reg[0] <= '0;
            q_reg[1] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                for (int b = 0; b < W; b++) begin
                    case ({j_o[p][b], k_o[p][b]})
                        2'b00: q_reg[p][b] <= q_fb[p][b];
                        2'b01: q_reg[p][b] <= 1'b0;
                        2'b10: q_reg[p][b] <= 1'b1;
                        2'b11: q_reg[p][b] <= ~q_fb[p][b];
                    endcase
                end
            end
        end
    end

    function automatic logic [W-1:0] exp_j(input int pol, input logic [W-1:0] q,
                                           input logic [W-1:0] t, input logic hold);
        if (hold) return '0;
        return (pol == 0) ? (t & ~q) : (t | q);
    endfunction

    function automatic logic [W-1:0] exp_k(input int pol, input logic [W-1:0] q,
                                           input logic [W-1:0] t, input logic hold);
        if (hold) return '0;
        return (pol == 0) ? (q & ~t) : ~(q & t);
    endfunction

    function automatic logic [W-1:0] target_of(input logic [1:0] mode, input logic [W-1:0] q,
                                               input logic [W-1:0] data);
        case (mode)
            MODE_LOAD:   return data;
            MODE_TOGGLE: return q ^ data;
            MODE_CLEAR:  return '0;
            default:     return q;
        endcase
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_err[p]  = 1'b0;
            m_cnt[p]  = 8'd0;
            m_mask[p] = '0;
        end
    endtask

    // One full request: accept, DRIVE, CHECK, DONE, with clr asserted during CHECK.
    task automatic run_req(input logic [1:0] mode, input logic [W-1:0] data, input logic clr);
        logic [W-1:0] q0 [2];
        logic [W-1:0] tgt [2];
        logic [W-1:0] fin [2];
        @(negedge CLK);
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = data;
        for (int p = 0; p < 2; p++) begin
            q0[p]  = q_fb[p];
            tgt[p] = target_of(mode, q0[p], data);
            fin[p] = tgt[p] & ~stuck;
            checks++;
            if (in_ready[p] !== 1'b1) begin
                failures++;
                $display("FAIL accept_ready p=%0d got=%b exp=1", p, in_ready[p]);
            end
        end
        @(negedge CLK);
        in_valid = 1'b0;
        in_mode  = 2'($urandom);
        in_data  = W'($urandom);
        for (int p = 0; p < 2; p++) begin
            checks++;
            if ({j_o[p], k_o[p], busy[p], in_ready[p]} !==
                {exp_j(p, q0[p], tgt[p], mode == MODE_HOLD),
                 exp_k(p, q0[p], tgt[p], mode == MODE_HOLD), 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL drive p=%0d got J=%h K=%h busy=%b rdy=%b exp J=%h K=%h busy=1 rdy=0",
                         p, j_o[p], k_o[p], busy[p], in_ready[p],
                         exp_j(p, q0[p], tgt[p], mode == MODE_HOLD),
                         exp_k(p, q0[p], tgt[p], mode == MODE_HOLD));
            end
        end
        @(negedge CLK);
        err_clr = clr;
        for (int p = 0; p < 2; p++) begin
            checks++;
            if ({j_o[p], k_o[p], busy[p], done[p], q_fb[p]} !== {{(2*W){1'b0}}, 1'b1, 1'b0, fin[p]}) begin
                failures++;
                $display("FAIL check_cycle p=%0d got J=%h K=%h busy=%b done=%b Q=%h exp J=0 K=0 busy=1 done=0 Q=%h",
                         p, j_o[p], k_o[p], busy[p], done[p], q_fb[p], fin[p]);
            end
            if (clr) begin
                m_err[p] = 1'b0;
                m_cnt[p] = 8'd0;
            end
            m_mask[p] = fin[p] ^ tgt[p];
            if (m_mask[p] != '0) begin
                m_err[p] = 1'b1;
                if (m_cnt[p] != 8'd255) m_cnt[p] = m_cnt[p] + 8'd1;
            end
        end
        @(negedge CLK);
        err_clr = 1'b0;
        for (int p = 0; p < 2; p++) begin
            checks++;
            if ({done[p], busy[p], in_ready[p], err[p], err_mask[p], err_count[p]} !==
                {1'b1, 1'b0, 1'b1, m_err[p], m_mask[p], m_cnt[p]}) begin
                failures++;
                $display("FAIL done_cycle p=%0d got done=%b busy=%b rdy=%b err=%b mask=%h cnt=%0d exp done=1 busy=0 rdy=1 err=%b mask=%h cnt=%0d",
                         p, done[p], busy[p], in_ready[p], err[p], err_mask[p], err_count[p],
                         m_err[p], m_mask[p], m_cnt[p]);
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        model_reset();
        for (int p = 0; p < 2; p++) begin
            checks++;
            if ({in_ready[p], j_o[p], k_o[p], busy[p], done[p], err[p], err_mask[p], err_count[p]} !== '0) begin
                failures++;
                $display("FAIL reset_state p=%0d got rdy=%b J=%h K=%h busy=%b done=%b err=%b mask=%h cnt=%0d exp all 0",
                         p, in_ready[p], j_o[p], k_o[p], busy[p], done[p], err[p], err_mask[p], err_count[p]);
            end
        end
        RST = 1'b0;
        @(negedge CLK);
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (in_ready[p] !== 1'b1) begin
                failures++;
                $display("FAIL reset_release_ready p=%0d got=%b exp=1", p, in_ready[p]);
            end
        end
    endtask

    task automatic test_load();
        run_req(MODE_LOAD, 8'hA5, 1'b0);
        for (int p = 0; p < 2; p++) begin
            checks++;
            if ({q_fb[p], err[p]} !== {8'hA5, 1'b0}) begin
                failures++;
                $display("FAIL load_a5 p=%0d got Q=%h err=%b exp Q=a5 err=0", p, q_fb[p], err[p]);
            end
        end
    endtask

    task automatic test_toggle();
        run_req(MODE_TOGGLE, 8'hFF, 1'b0);
        for (int p = 0; p < 2; p++) begin
            checks++;
            if ({q_fb[p], err_mask[p]} !== {8'h5A, 8'h00}) begin
                failures++;
                $display("FAIL toggle_ff p=%0d got Q=%h mask=%h exp Q=5a mask=00", p, q_fb[p], err_mask[p]);
            end
        end
    endtask

    task automatic test_stuck();
        stuck = 8'h08;
        run_req(MODE_LOAD, 8'h08, 1'b0);
        for (int p = 0; p < 2; p++) begin
            checks++;
            if ({err[p], err_mask[p], err_count[p]} !== {1'b1, 8'h08, 8'd1}) begin
                failures++;
                $display("FAIL stuck_first p=%0d got err=%b mask=%h cnt=%0d exp err=1 mask=08 cnt=1",
                         p, err[p], err_mask[p], err_count[p]);
            end
        end
        for (int n = 0; n < 300; n++) run_req(MODE_LOAD, 8'h08, 1'b0);
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (err_count[p] !== 8'd255) begin
                failures++;
                $display("FAIL count_saturate p=%0d got=%0d exp=255", p, err_count[p]);
            end
        end
    endtask

    task automatic test_err_clr();
        @(negedge CLK);
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        model_reset();
        for (int p = 0; p < 2; p++) begin
            checks++;
            if ({err[p], err_mask[p], err_count[p]} !== '0) begin
                failures++;
                $display("FAIL clr_alone p=%0d got err=%b mask=%h cnt=%0d exp 0",
                         p, err[p], err_mask[p], err_count[p]);
            end
        end
        repeat (5) run_req(MODE_LOAD, 8'h08, 1'b0);
        run_req(MODE_LOAD, 8'h08, 1'b1);
        for (int p = 0; p < 2; p++) begin
            checks++;
            if ({err[p], err_mask[p], err_count[p]} !== {1'b1, 8'h08, 8'd1}) begin
                failures++;
                $display("FAIL clr_with_fail p=%0d got err=%b mask=%h cnt=%0d exp err=1 mask=08 cnt=1",
                         p, err[p], err_mask[p], err_count[p]);
            end
        end
        stuck = 8'h00;
        run_req(MODE_LOAD, 8'h3C, 1'b0);
        for (int p = 0; p < 2; p++) begin
            checks++;
            if ({err[p], err_mask[p], err_count[p]} !== {1'b1, 8'h00, 8'd1}) begin
                failures++;
                $display("FAIL pass_keeps_err p=%0d got err=%b mask=%h cnt=%0d exp err=1 mask=00 cnt=1",
                         p, err[p], err_mask[p], err_count[p]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] q0 [2];
        int low_cycles;
        run_req(MODE_LOAD, 8'hC3, 1'b0);
        @(negedge CLK);
        q0[0] = q_fb[0];
        q0[1] = q_fb[1];
        in_valid = 1'b1;
        in_mode  = MODE_HOLD;
        in_data  = 8'hFF;
        low_cycles = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (in_ready[0] !== 1'b1) low_cycles++;
            if (c == 0) begin
                in_mode = MODE_CLEAR;
                for (int p = 0; p < 2; p++) begin
                    checks++;
                    if ({j_o[p], k_o[p]} !== '0) begin
                        failures++;
                        $display("FAIL hold_jk p=%0d got J=%h K=%h exp 0", p, j_o[p], k_o[p]);
                    end
                end
            end
            if (c == 2) begin
                for (int p = 0; p < 2; p++) begin
                    checks++;
                    if ({done[p], in_ready[p], q_fb[p]} !== {1'b1, 1'b1, q0[p]}) begin
                        failures++;
                        $display("FAIL hold_done p=%0d got done=%b rdy=%b Q=%h exp done=1 rdy=1 Q=%h",
                                 p, done[p], in_ready[p], q_fb[p], q0[p]);
                    end
                end
            end
            if (c == 3) begin
                in_valid = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    checks++;
                    if ({busy[p], j_o[p], k_o[p]} !==
                        {1'b1, exp_j(p, q0[p], '0, 1'b0), exp_k(p, q0[p], '0, 1'b0)}) begin
                        failures++;
                        $display("FAIL clear_accepted_in_done p=%0d got busy=%b J=%h K=%h", p, busy[p], j_o[p], k_o[p]);
                    end
                end
            end
            if (c == 5) begin
                for (int p = 0; p < 2; p++) begin
                    checks++;
                    if ({done[p], q_fb[p]} !== {1'b1, 8'h00}) begin
                        failures++;
                        $display("FAIL clear_done p=%0d got done=%b Q=%h exp done=1 Q=00", p, done[p], q_fb[p]);
                    end
                end
            end
        end
        checks++;
        if (low_cycles !== 4) begin
            failures++;
            $display("FAIL ready_low_cycles got=%0d exp=4", low_cycles);
        end
        m_mask[0] = '0;
        m_mask[1] = '0;
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        in_valid = 1'b1;
        in_mode  = MODE_LOAD;
        in_data  = 8'h96;
        @(negedge CLK);
        in_valid = 1'b0;
        RST = 1'b1;
        #1;
        for (int p = 0; p < 2; p++) begin
            checks++;
            if ({j_o[p], k_o[p], busy[p], done[p], in_ready[p]} !== '0) begin
                failures++;
                $display("FAIL reset_mid p=%0d got J=%h K=%h busy=%b done=%b rdy=%b exp 0",
                         p, j_o[p], k_o[p], busy[p], done[p], in_ready[p]);
            end
        end
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        for (int p = 0; p < 2; p++) begin
            checks++;
            if ({in_ready[p], busy[p], done[p]} !== 3'b100) begin
                failures++;
                $display("FAIL reset_mid_release p=%0d got rdy=%b busy=%b done=%b exp rdy=1 busy=0 done=0",
                         p, in_ready[p], busy[p], done[p]);
            end
        end
        repeat (2) begin
            @(negedge CLK);
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (done[p] !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_mid_no_done p=%0d got=%b exp=0", p, done[p]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            stuck = '0;
            if ($urandom_range(0, 3) == 0) stuck[$urandom_range(0, W-1)] = 1'b1;
            run_req(2'($urandom), W'($urandom), ($urandom_range(0, 4) == 0));
        end
        stuck = '0;
    endtask

    initial begin
        RST      = 1'b1;
        in_valid = 1'b0;
        in_mode  = MODE_LOAD;
        in_data  = '0;
        err_clr  = 1'b0;
        stuck    = '0;
        test_reset();
        test_load();
        test_toggle();
        test_stuck();
        test_err_clr();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
